// File: rtl/stream_arbiter.sv
// Round-robin arbiter for NUM_INPUTS valid/ready requesters into one registered output stage.
// A packet holds the output until its last beat is accepted.
module stream_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH_BITS = 8,
  localparam int INDEX_BITS = $clog2(NUM_INPUTS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            input_valid,
  output logic [NUM_INPUTS-1:0]            input_ready,
  input  logic [NUM_INPUTS*WIDTH_BITS-1:0] input_data,
  input  logic [NUM_INPUTS-1:0]            input_last,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic [WIDTH_BITS-1:0]            output_data,
  output logic                             output_last,
  output logic [INDEX_BITS-1:0]            output_index
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   lock_q, lock_d;
  logic [INDEX_BITS-1:0]   last_grant_q, last_grant_d;
  logic                    valid_q, valid_d;
  logic [WIDTH_BITS-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;

  logic [WIDTH_BITS-1:0]   in_data_arr [NUM_INPUTS];
  logic [INDEX_BITS-1:0]   grant_idx;
  logic [INDEX_BITS-1:0]   cand_idx;
  logic                    grant_found;
  logic [INDEX_BITS-1:0]   sel_idx;
  logic                    can_load;
  logic                    in_hs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign in_data_arr[gi] = input_data[gi*WIDTH_BITS +: WIDTH_BITS];
    end
  endgenerate

  assign can_load = !valid_q || output_ready;

  // Scan starts just after the previous winner so that every requester gets a turn.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand_idx = INDEX_BITS'((int'(last_grant_q) + k) % NUM_INPUTS);
      if (!grant_found && input_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    input_ready = '0;
    sel_idx     = (state_q == LOCKED) ? lock_q : grant_idx;
    if (!reset) begin
      if (state_q == LOCKED) begin
        input_ready[lock_q] = can_load;
      end else if (grant_found) begin
        input_ready[grant_idx] = can_load;
      end
    end
  end

  assign in_hs = |(input_valid & input_ready);

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    index_d      = index_q;
    if (in_hs) begin
      valid_d = 1'b1;
      data_d  = in_data_arr[sel_idx];
      last_d  = input_last[sel_idx];
      index_d = sel_idx;
      if (input_last[sel_idx]) begin
        state_d      = IDLE;
        last_grant_d = sel_idx;
      end else begin
        state_d = LOCKED;
        lock_d  = sel_idx;
      end
    end else if (output_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_q       <= '0;
      last_grant_q <= INDEX_BITS'(NUM_INPUTS - 1);
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      index_q      <= index_d;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = data_q;
  assign output_last  = last_q;
  assign output_index = index_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: reset, rotation, locking, backpressure, mid-packet reset, wrap.
module tb_stream_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  input_valid;
  logic [3:0]  input_ready;
  logic [31:0] input_data;
  logic [3:0]  input_last;
  logic        output_valid;
  logic        output_ready;
  logic [7:0]  output_data;
  logic        output_last;
  logic [1:0]  output_index;

  int checks;
  int failures;

  stream_arbiter #(.NUM_INPUTS(4), .WIDTH_BITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .output_index (output_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, got);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    input_valid = v;
    input_last  = l;
    input_data  = d;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic cyc;
    @(negedge clock);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic [1:0] idx);
    check({tag, ".valid"}, 32'(output_valid), 32'(v));
    if (v) begin
      check({tag, ".data"},  32'(output_data),  32'(d));
      check({tag, ".last"},  32'(output_last),  32'(l));
      check({tag, ".index"}, 32'(output_index), 32'(idx));
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    output_ready = 1'b1;
    set_in(4'hF, 4'hF, 32'h0);

    // Reset: ready low even with requests pending, outputs cleared
    cyc(); #1;
    check("rst.ready", 32'(input_ready), 32'h0);
    cyc(); #1;
    check("rst.ready2", 32'(input_ready), 32'h0);
    check("rst.valid", 32'(output_valid), 32'h0);
    check("rst.data", 32'(output_data), 32'h0);
    check("rst.last", 32'(output_last), 32'h0);
    check("rst.index", 32'(output_index), 32'h0);
    reset = 1'b0;
    set_in(4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check($sformatf("idle%0d.ready", i), 32'(input_ready), 32'h0);
      check($sformatf("idle%0d.valid", i), 32'(output_valid), 32'h0);
    end

    // Fairness rotation, single-beat packets from all four requesters
    for (int k = 0; k < 7; k++) begin
      cyc();
      set_in(4'hF, 4'hF, 32'h43424140);
      #1;
      check($sformatf("rot%0d.ready", k), 32'(input_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0)
        check_out($sformatf("rot%0d", k), 1'b1, 8'(8'h40 + ((k - 1) % 4)), 1'b1, 2'((k - 1) % 4));
    end
    // Grants so far 0,1,2,3,0,1,2 -> last_grant=2; only requester 2 now valid
    cyc();
    set_in(4'b0100, 4'hF, 32'h00420000);
    #1;
    check_out("rot7", 1'b1, 8'h42, 1'b1, 2'd2);
    check("wrap.ready", 32'(input_ready), 32'h4);
    cyc();
    set_in(4'b0100, 4'hF, 32'h00770000);
    #1;
    check_out("wrap0", 1'b1, 8'h42, 1'b1, 2'd2);
    check("wrap.nobubble", 32'(input_ready), 32'h4);
    cyc();
    set_in(4'h0, 4'h0, 32'h0);
    #1;
    check_out("wrap1", 1'b1, 8'h77, 1'b1, 2'd2);
    cyc(); #1;
    check("wrap.drain", 32'(output_valid), 32'h0);

    // Lock: requester 1 sends three beats while requester 2 waits
    cyc();
    set_in(4'b0110, 4'b0100, 32'h00221100);
    #1;
    check("lock.a.ready", 32'(input_ready), 32'h2);
    cyc();
    set_in(4'b0110, 4'b0100, 32'h00221200);
    #1;
    check("lock.b.ready", 32'(input_ready), 32'h2);
    check_out("lock.b", 1'b1, 8'h11, 1'b0, 2'd1);
    cyc();
    set_in(4'b0110, 4'b0110, 32'h00221300);
    #1;
    check("lock.c.ready", 32'(input_ready), 32'h2);
    check_out("lock.c", 1'b1, 8'h12, 1'b0, 2'd1);
    cyc();
    set_in(4'b0100, 4'b0100, 32'h00220000);
    #1;
    check("lock.d.ready", 32'(input_ready), 32'h4);
    check_out("lock.d", 1'b1, 8'h13, 1'b1, 2'd1);
    cyc();
    set_in(4'h0, 4'h0, 32'h0);
    #1;
    check_out("lock.e", 1'b1, 8'h22, 1'b1, 2'd2);
    cyc(); #1;
    check("lock.drain", 32'(output_valid), 32'h0);

    // Backpressure: requester 0 beat held while output_ready is low
    cyc();
    output_ready = 1'b0;
    set_in(4'b0001, 4'b0001, 32'h000000A5);
    #1;
    check("bp.load.ready", 32'(input_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_in(4'b0010, 4'b0010, 32'h00005A00);
      #1;
      check($sformatf("bp%0d.ready", i), 32'(input_ready), 32'h0);
      check_out($sformatf("bp%0d", i), 1'b1, 8'hA5, 1'b1, 2'd0);
    end
    cyc();
    output_ready = 1'b1;
    #1;
    check("bp.release.ready", 32'(input_ready), 32'h2);
    check_out("bp.release", 1'b1, 8'hA5, 1'b1, 2'd0);
    cyc();
    set_in(4'h0, 4'h0, 32'h0);
    #1;
    check_out("bp.replace", 1'b1, 8'h5A, 1'b1, 2'd1);
    cyc(); #1;
    check("bp.drain", 32'(output_valid), 32'h0);

    // Reset while requester 3 holds the lock
    cyc();
    set_in(4'b1000, 4'b0000, 32'h33000000);
    #1;
    check("mrst.a.ready", 32'(input_ready), 32'h8);
    cyc();
    set_in(4'b1001, 4'b0001, 32'h3400000A);
    #1;
    check("mrst.b.ready", 32'(input_ready), 32'h8);
    check_out("mrst.b", 1'b1, 8'h33, 1'b0, 2'd3);
    reset = 1'b1;
    #1;
    check("mrst.inreset.ready", 32'(input_ready), 32'h0);
    cyc();
    reset = 1'b0;
    #1;
    check("mrst.c.valid", 32'(output_valid), 32'h0);
    check("mrst.c.ready", 32'(input_ready), 32'h1);
    cyc();
    set_in(4'h0, 4'h0, 32'h0);
    #1;
    check_out("mrst.d", 1'b1, 8'h0A, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
